// File: rtl/boid_frame_scanner.sv
// boid_frame_scanner: clears the boid framebuffer, then plots every boid's position.
// Optional feature macro BOID_SCAN_CROSS_EN: plot a 5-pixel cross marker per boid instead of one pixel.
module boid_frame_scanner #(
  parameter int NUM_BOIDS = 128,
  parameter int IDX_W = $clog2(NUM_BOIDS),
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int ADDR_W = 19
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              frame_start_i,
  output logic [IDX_W-1:0]  boid_idx_o,
  input  logic [X_W-1:0]    boid_x_i,
  input  logic [Y_W-1:0]    boid_y_i,
  output logic              fb_clear_o,
  output logic              fb_we_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        overrun_count_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WRITE, DONE} state_t;
  state_t state_q;
  logic pending_q, fb_clear_q, fb_we_q, busy_q, done_q;
  logic [IDX_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] ovr_q;
  logic [31:0] wx_d, wy_d;
  logic wv_d;
  logic [ADDR_W-1:0] waddr_d;
`ifdef BOID_SCAN_CROSS_EN
  logic [X_W-1:0] px_q;
  logic [Y_W-1:0] py_q;
  logic [2:0] sub_q, arm_d;
  // Coordinate of the pixel emitted next: centre from the live inputs, arms from the latched centre.
  // An x-1/y-1 arm at 0 wraps to a huge value and fails the bounds test below.
  always_comb begin
    arm_d = (state_q == FETCH) ? 3'd0 : sub_q + 3'd1;
    wx_d = ((state_q == FETCH) ? 32'(boid_x_i) : 32'(px_q)) +
           ((arm_d == 3'd2) ? 32'd1 : (arm_d == 3'd1) ? 32'hFFFF_FFFF : 32'd0);
    wy_d = ((state_q == FETCH) ? 32'(boid_y_i) : 32'(py_q)) +
           ((arm_d == 3'd4) ? 32'd1 : (arm_d == 3'd3) ? 32'hFFFF_FFFF : 32'd0);
  end
`else
  // Single-pixel mode only ever plots the freshly fetched position.
  always_comb begin
    wx_d = 32'(boid_x_i);
    wy_d = 32'(boid_y_i);
  end
`endif
  assign wv_d = (wx_d < 32'(H_RES)) && (wy_d < 32'(V_RES));
  assign waddr_d = ADDR_W'(wy_d * 32'(H_RES) + wx_d);
  // Scan state machine with all outputs registered; one extra request can queue while busy.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      idx_q <= '0;
      fb_clear_q <= 1'b0;
      fb_we_q <= 1'b0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= '0;
`ifdef BOID_SCAN_CROSS_EN
      px_q <= '0;
      py_q <= '0;
      sub_q <= '0;
`endif
    end else begin
      fb_clear_q <= 1'b0;
      fb_we_q <= 1'b0;
      done_q <= 1'b0;
      if (frame_start_i && state_q != IDLE) begin
        if (!pending_q) pending_q <= 1'b1;
        else if (ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      end
      case (state_q)
        IDLE: if (frame_start_i || pending_q) begin
          state_q <= CLEAR;
          fb_clear_q <= 1'b1;
          idx_q <= '0;
          pending_q <= 1'b0;
          busy_q <= 1'b1;
        end
        CLEAR: state_q <= FETCH;
        FETCH: begin
          state_q <= WRITE;
          fb_we_q <= wv_d;
          if (wv_d) addr_q <= waddr_d;
`ifdef BOID_SCAN_CROSS_EN
          px_q <= boid_x_i;
          py_q <= boid_y_i;
          sub_q <= 3'd0;
`endif
        end
        WRITE: begin
`ifdef BOID_SCAN_CROSS_EN
          if (sub_q != 3'd4) begin
            sub_q <= sub_q + 3'd1;
            fb_we_q <= wv_d;
            if (wv_d) addr_q <= waddr_d;
          end else
`endif
          if (idx_q == IDX_W'(NUM_BOIDS - 1)) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            state_q <= FETCH;
          end
        end
        DONE: if (pending_q) begin
          state_q <= CLEAR;
          fb_clear_q <= 1'b1;
          idx_q <= '0;
          pending_q <= 1'b0;
        end else begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign boid_idx_o = idx_q;
  assign fb_clear_o = fb_clear_q;
  assign fb_we_o = fb_we_q;
  assign fb_addr_o = addr_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign overrun_count_o = ovr_q;
endmodule

// File: tb/tb_boid_frame_scanner.sv
// tb_boid_frame_scanner: directed and random scans checked against a cycle-offset reference model.
module tb_boid_frame_scanner;
  localparam int NB = 4;
  localparam int H = 640;
  localparam int V = 480;
  localparam int AW = 19;
`ifdef BOID_SCAN_CROSS_EN
  localparam int P = 6;
`else
  localparam int P = 2;
`endif
  localparam int LAST = P * NB + 1;
  logic clock = 1'b0, reset = 1'b1, frame_start = 1'b0;
  logic [1:0] boid_idx;
  logic [9:0] boid_x;
  logic [8:0] boid_y;
  logic fb_clear, fb_we, busy, done;
  logic [AW-1:0] fb_addr;
  logic [7:0] overrun_count;
  logic [9:0] bx[NB];
  logic [8:0] by[NB];
  int errors = 0, checks = 0, cyc = 0;
  int m_act = 0, m_off = 0, m_pend = 0, m_ovr = 0, m_idx = 0, m_addr = 0, m_px = 0, m_py = 0, e_we = 0;
  int wq[$], dq[$], cq[$], exp_w[$];
  int dxs[5] = '{0, -1, 1, 0, 0};
  int dys[5] = '{0, 0, 0, -1, 1};
  assign boid_x = bx[boid_idx];
  assign boid_y = by[boid_idx];
  always #5 clock = ~clock;
  boid_frame_scanner #(.NUM_BOIDS(NB), .IDX_W(2), .H_RES(H), .V_RES(V), .X_W(10), .Y_W(9), .ADDR_W(AW)) dut (
    .clock_i(clock), .reset_i(reset), .frame_start_i(frame_start),
    .boid_idx_o(boid_idx), .boid_x_i(boid_x), .boid_y_i(boid_y),
    .fb_clear_o(fb_clear), .fb_we_o(fb_we), .fb_addr_o(fb_addr),
    .busy_o(busy), .done_o(done), .overrun_count_o(overrun_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic setpos(input int i, input int x, input int y);
    bx[i] = 10'(x);
    by[i] = 9'(y);
  endtask
  task automatic bump_ovr();
    if (m_ovr < 255) m_ovr++;
  endtask
  // One clock: drive inputs, advance the model by the edge, then compare every output.
  task automatic step(input logic fs, input logic r);
    int ph, arm, ax, ay;
    frame_start = fs;
    reset = r;
    @(posedge clock);
    if (r) begin
      m_act = 0; m_pend = 0; m_ovr = 0; m_idx = 0; m_addr = 0; e_we = 0;
    end else begin
      if (m_act != 0 && m_off >= 1 && m_off <= P * NB && (m_off - 1) % P == 0) begin
        m_px = int'(bx[(m_off - 1) / P]);
        m_py = int'(by[(m_off - 1) / P]);
      end
      if (m_act == 0) begin
        if (fs || m_pend != 0) begin m_act = 1; m_off = 0; m_pend = 0; end
      end else if (m_off == LAST) begin
        if (m_pend != 0) begin
          m_off = 0; m_pend = 0;
          if (fs) bump_ovr();
        end else begin
          m_act = 0; m_pend = fs ? 1 : 0;
        end
      end else begin
        m_off++;
        if (fs) begin
          if (m_pend != 0) bump_ovr();
          else m_pend = 1;
        end
      end
      e_we = 0;
      if (m_act != 0 && m_off == 0) m_idx = 0;
      if (m_act != 0 && m_off >= 1 && m_off <= P * NB) begin
        m_idx = (m_off - 1) / P;
        ph = (m_off - 1) % P;
        if (ph >= 1) begin
          arm = ph - 1;
          ax = m_px + dxs[arm];
          ay = m_py + dys[arm];
          if (ax >= 0 && ax < H && ay >= 0 && ay < V) begin
            e_we = 1;
            m_addr = (ay * H + ax) % (1 << AW);
          end
        end
      end
    end
    cyc++;
    #1;
    chk("busy", 32'(busy), 32'(m_act != 0));
    chk("fb_clear", 32'(fb_clear), 32'(m_act != 0 && m_off == 0));
    chk("done", 32'(done), 32'(m_act != 0 && m_off == LAST));
    chk("boid_idx", 32'(boid_idx), 32'(m_idx));
    chk("fb_we", 32'(fb_we), 32'(e_we));
    chk("fb_addr", 32'(fb_addr), 32'(m_addr));
    chk("overrun", 32'(overrun_count), 32'(m_ovr));
    if (fb_we === 1'b1) wq.push_back(int'(fb_addr));
    if (done === 1'b1) dq.push_back(cyc);
    if (fb_clear === 1'b1) cq.push_back(cyc);
  endtask
  task automatic clearq();
    wq.delete(); dq.delete(); cq.delete();
    cyc = 0;
  endtask
  task automatic default_pos();
    setpos(0, 0, 0);
`ifdef BOID_SCAN_CROSS_EN
    setpos(1, 100, 100);
`else
    setpos(1, 639, 479);
`endif
    setpos(2, 10, 2);
    setpos(3, 5, 1);
  endtask
  task automatic chk_list(input string tag);
    chk({tag, "_count"}, 32'(wq.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      chk(tag, (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
  endtask
  initial begin
    default_pos();
    step(0, 1);
    step(0, 1);
    // basic scan
    clearq();
    for (int c = 0; c < 15; c++) step(c == 0, 0);
    chk("t1_clear_cyc", cq.size() > 0 ? 32'(cq[0]) : 32'hFFFF_FFFF, 32'd1);
    chk("t1_done_cyc", dq.size() > 0 ? 32'(dq[0]) : 32'hFFFF_FFFF, 32'(P * NB + 2));
`ifdef BOID_SCAN_CROSS_EN
    exp_w = '{0, 1, 640, 64100, 64099, 64101, 63460, 64740, 1290, 1289, 1291, 650, 1930, 645, 644, 646, 5, 1285};
`else
    exp_w = '{0, 307199, 1290, 645};
`endif
    chk_list("t1_wr");
    // out-of-range boids
    setpos(1, 640, 5);
    setpos(2, 3, 480);
    clearq();
    for (int c = 0; c < 30; c++) step(c == 0, 0);
    chk("t2_done_cyc", dq.size() > 0 ? 32'(dq[0]) : 32'hFFFF_FFFF, 32'(P * NB + 2));
`ifdef BOID_SCAN_CROSS_EN
    exp_w = '{0, 1, 640, 3839, 306563, 645, 644, 646, 5, 1285};
`else
    exp_w = '{0, 645};
`endif
    chk_list("t2_wr");
    // queued request and overrun
    default_pos();
    step(0, 1);
    clearq();
    for (int c = 0; c < 2 * LAST + 6; c++) step(c == 0 || c == 4 || c == 6, 0);
    chk("t3_ovr", 32'(overrun_count), 32'd1);
    chk("t3_done_n", 32'(dq.size()), 32'd2);
    chk("t3_done0", dq.size() > 0 ? 32'(dq[0]) : 32'hFFFF_FFFF, 32'(LAST + 1));
    chk("t3_done1", dq.size() > 1 ? 32'(dq[1]) : 32'hFFFF_FFFF, 32'(2 * LAST + 2));
    chk("t3_clear1", cq.size() > 1 ? 32'(cq[1]) : 32'hFFFF_FFFF, 32'(LAST + 2));
    // reset mid-scan, then restart
    clearq();
    for (int c = 0; c < 14; c++) step(c == 0 || c == 8, c == 5);
    chk("t4_no_done", 32'(dq.size()), 32'd0);
    chk("t4_clear_n", 32'(cq.size()), 32'd2);
    chk("t4_clear1", cq.size() > 1 ? 32'(cq[1]) : 32'hFFFF_FFFF, 32'd9);
    // reset beats a simultaneous request
    step(0, 1);
    step(1, 1);
    step(0, 0);
    chk("t5_rst_wins", 32'(busy), 32'd0);
    // overrun saturation
    for (int c = 0; c < 400; c++) step(1, 0);
    chk("t6_sat", 32'(overrun_count), 32'd255);
    step(0, 1);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0)
        setpos(int'($urandom_range(0, NB - 1)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(640, 1023)) :
               ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 639)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 511)) :
               ($urandom_range(0, 5) == 0) ? 479 : int'($urandom_range(0, 479)));
      step($urandom_range(0, 14) == 0, $urandom_range(0, 599) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
